// File: rtl/monitor_display_7segmentos_pkg.sv
// ============================================================================
// monitor_display_7segmentos_pkg
// Shared constants for the 7-segment monitor: segment patterns, blanks, defaults.
// Revision: 1.0
// ============================================================================
`default_nettype none

package monitor_display_7segmentos_pkg;

  // Active-low gfedcba patterns, indexed by the hex value they display
  localparam logic [6:0] C_PATRONES [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] C_SEG_BLANCO     = 7'h7F;
  localparam logic [3:0] C_ANODO_BLANCO   = 4'b1111;
  localparam int         C_P_ESTABLE_DEF  = 4;

  // Index of the lowest active-low anode bit
  function automatic logic [1:0] f_indice_anodo(input logic [3:0] i_anodo);
    logic [1:0] v_idx;
    v_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (!i_anodo[k]) v_idx = 2'(k);
    end
    return v_idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/monitor_display_7segmentos_decodificador.sv
// ============================================================================
// decodificador_7seg_a_hex
// Active-low 7-segment pattern to hex nibble, with a valid flag for known codes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module decodificador_7seg_a_hex
  import monitor_display_7segmentos_pkg::*;
(
  input  logic [6:0] i_Patron,
  output logic [3:0] o_Nibble,
  output logic       o_Valido
);

  always_comb begin
    o_Nibble = 4'h0;
    o_Valido = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (i_Patron == C_PATRONES[k]) begin
        o_Nibble = 4'(k);
        o_Valido = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/monitor_display_7segmentos.sv
// ============================================================================
// monitor_display_7segmentos
// Recovers four hex digits from multiplexed 7-seg lines, publishes full frames.
// Revision: 1.0
// ============================================================================
`default_nettype none

module monitor_display_7segmentos
  import monitor_display_7segmentos_pkg::*;
#(
  parameter int P_ESTABLE = C_P_ESTABLE_DEF
) (
  input  logic       i_Reloj,
  input  logic       i_Reset,
  input  logic [6:0] i_Segmentos,
  input  logic [3:0] i_Anodo_4_Bits,
  output logic [3:0] o_Datos_0,
  output logic [3:0] o_Datos_1,
  output logic [3:0] o_Datos_2,
  output logic [3:0] o_Datos_3,
  output logic       o_Trama_Valida,
  output logic       o_Cambio,
  output logic       o_Error_Patron,
  output logic       o_Error_Anodo
);

  localparam logic [7:0] C_LIMITE = 8'(P_ESTABLE);

  logic [10:0] w_Entrada;
  logic        w_Igual;
  logic [8:0]  w_Racha;
  logic        w_Captura;
  logic        w_Un_Anodo;
  logic [1:0]  w_Indice;
  logic [3:0]  w_Nibble;
  logic        w_Patron_Valido;
  logic [3:0]  w_Mascara_Nueva;
  logic [15:0] w_Sombra_Nueva;

  logic [10:0] r_Previo;
  logic [7:0]  r_Cuenta;
  logic        r_Capturado;
  logic [3:0]  r_Mascara;
  logic [15:0] r_Sombra;
  logic [15:0] r_Anterior;
  logic [15:0] r_Datos;
  logic        r_Trama;
  logic        r_Cambio;
  logic        r_Err_Patron;
  logic        r_Err_Anodo;

  decodificador_7seg_a_hex u_decodificador (
    .i_Patron (i_Segmentos),
    .o_Nibble (w_Nibble),
    .o_Valido (w_Patron_Valido)
  );

  assign w_Entrada  = {i_Anodo_4_Bits, i_Segmentos};
  assign w_Igual    = (w_Entrada == r_Previo);
  // Length of the current dwell including this edge; the first edge counts as 1
  assign w_Racha    = w_Igual ? ({1'b0, r_Cuenta} + 9'd2) : 9'd1;
  assign w_Captura  = !(w_Igual && r_Capturado) && (w_Racha >= 9'(P_ESTABLE));
  assign w_Un_Anodo = ($countones(~i_Anodo_4_Bits) == 1);
  assign w_Indice   = f_indice_anodo(i_Anodo_4_Bits);
  assign w_Mascara_Nueva = r_Mascara | (4'b0001 << w_Indice);

  always_comb begin
    w_Sombra_Nueva = r_Sombra;
    w_Sombra_Nueva[{w_Indice, 2'b00} +: 4] = w_Nibble;
  end

  always_ff @(posedge i_Reloj or negedge i_Reset) begin
    if (!i_Reset) begin
      r_Previo     <= '0;
      r_Cuenta     <= '0;
      r_Capturado  <= 1'b0;
      r_Mascara    <= '0;
      r_Sombra     <= '0;
      r_Anterior   <= '0;
      r_Datos      <= '0;
      r_Trama      <= 1'b0;
      r_Cambio     <= 1'b0;
      r_Err_Patron <= 1'b0;
      r_Err_Anodo  <= 1'b0;
    end else begin
      r_Previo    <= w_Entrada;
      r_Cuenta    <= !w_Igual ? 8'd0 : ((r_Cuenta >= C_LIMITE) ? r_Cuenta : r_Cuenta + 8'd1);
      r_Capturado <= w_Captura | (w_Igual & r_Capturado);
      r_Trama     <= 1'b0;
      r_Cambio    <= 1'b0;
      if (w_Captura && (i_Anodo_4_Bits != C_ANODO_BLANCO)) begin
        if (!w_Un_Anodo) begin
          r_Err_Anodo <= 1'b1;
        end else if (!w_Patron_Valido) begin
          r_Err_Patron <= 1'b1;
        end else begin
          r_Sombra <= w_Sombra_Nueva;
          if (w_Mascara_Nueva == 4'b1111) begin
            r_Mascara  <= '0;
            r_Datos    <= w_Sombra_Nueva;
            r_Trama    <= 1'b1;
            r_Cambio   <= (w_Sombra_Nueva != r_Anterior);
            r_Anterior <= w_Sombra_Nueva;
          end else begin
            r_Mascara  <= w_Mascara_Nueva;
          end
        end
      end
    end
  end

  assign o_Datos_0      = r_Datos[3:0];
  assign o_Datos_1      = r_Datos[7:4];
  assign o_Datos_2      = r_Datos[11:8];
  assign o_Datos_3      = r_Datos[15:12];
  assign o_Trama_Valida = r_Trama;
  assign o_Cambio       = r_Cambio;
  assign o_Error_Patron = r_Err_Patron;
  assign o_Error_Anodo  = r_Err_Anodo;

endmodule

`default_nettype wire

// File: tb/tb_monitor_display_7segmentos.sv
// ============================================================================
// tb_monitor_display_7segmentos
// Directed plus randomized bench with a frame-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_monitor_display_7segmentos;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg = 7'h7F;
  logic [3:0] an = 4'hF;
  logic [3:0] d0, d1, d2, d3;
  logic       tv, ca, ep, ea;

  int total = 0;
  int bad   = 0;

  logic [6:0] tbl [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  monitor_display_7segmentos #(.P_ESTABLE(P)) dut (
    .i_Reloj        (clk),
    .i_Reset        (rst_n),
    .i_Segmentos    (seg),
    .i_Anodo_4_Bits (an),
    .o_Datos_0      (d0),
    .o_Datos_1      (d1),
    .o_Datos_2      (d2),
    .o_Datos_3      (d3),
    .o_Trama_Valida (tv),
    .o_Cambio       (ca),
    .o_Error_Patron (ep),
    .o_Error_Anodo  (ea)
  );

  always #5 clk = ~clk;

  // Reference model: run length of identical samples, digit slots, frame publish
  logic [3:0]  m_sh [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0]  m_mk   = 4'h0;
  logic [15:0] m_prev = 16'h0;
  logic [10:0] m_last = 11'h0;
  int          m_run  = 0;
  int          m_lows, m_n, m_v;
  logic [15:0] m_f;
  logic [15:0] e_datos = 16'h0;
  logic        e_tv = 1'b0, e_ca = 1'b0, e_ep = 1'b0, e_ea = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) m_sh[k] = 4'h0;
      m_mk = 4'h0; m_prev = 16'h0; m_last = 11'h0; m_run = 0;
      e_datos = 16'h0; e_tv = 1'b0; e_ca = 1'b0; e_ep = 1'b0; e_ea = 1'b0;
    end else begin
      e_tv = 1'b0;
      e_ca = 1'b0;
      if ({an, seg} == m_last) m_run = m_run + 1;
      else m_run = 1;
      m_last = {an, seg};
      if (m_run == P && an != 4'hF) begin
        m_lows = 0; m_n = 0; m_v = -1;
        for (int k = 0; k < 4; k++) if (!an[k]) begin m_lows++; m_n = k; end
        for (int j = 0; j < 16; j++) if (seg == tbl[j]) m_v = j;
        if (m_lows > 1) e_ea = 1'b1;
        else if (m_v < 0) e_ep = 1'b1;
        else begin
          m_sh[m_n] = 4'(m_v);
          m_mk[m_n] = 1'b1;
          if (m_mk == 4'hF) begin
            m_f     = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
            e_ca    = (m_f != m_prev);
            m_prev  = m_f;
            e_datos = m_f;
            e_tv    = 1'b1;
            m_mk    = 4'h0;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    total++;
    if ({d3, d2, d1, d0, tv, ca, ep, ea} !== {e_datos, e_tv, e_ca, e_ep, e_ea}) begin
      bad++;
      $display("FAIL model t=%0t got datos=%h tv=%b ca=%b ep=%b ea=%b exp datos=%h tv=%b ca=%b ep=%b ea=%b",
               $time, {d3, d2, d1, d0}, tv, ca, ep, ea, e_datos, e_tv, e_ca, e_ep, e_ea);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    an  = 4'hF;
    seg = 7'h7F;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic scan_frame(input logic [15:0] d, input int dw,
                            output logic [15:0] got, output logic got_tv, output logic got_ca);
    got = 16'h0; got_tv = 1'b0; got_ca = 1'b0;
    for (int k = 0; k < 4; k++) begin
      an  = ~(4'b0001 << k);
      seg = tbl[d[k*4 +: 4]];
      for (int c = 0; c < dw; c++) begin
        @(negedge clk);
        if (k == 3 && c == P - 1) begin
          got = {d3, d2, d1, d0}; got_tv = tv; got_ca = ca;
        end
      end
    end
  endtask

  logic [15:0] s_d;
  logic        s_tv, s_ca;
  logic [3:0]  r_an;

  initial begin
    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      an  = 4'($urandom);
      seg = 7'($urandom);
      @(negedge clk);
      chk("reset_outs", {16'(0), d3, d2, d1, d0, tv, ca, ep, ea}, 32'h0);
    end
    an = 4'hF; seg = 7'h7F;
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Basic frame 1,2,3,4 then identical repeat
    dwell(4'hE, 7'h79, P); dwell(4'hD, 7'h24, P); dwell(4'hB, 7'h30, P); dwell(4'h7, 7'h19, P);
    chk("f1_tv", {31'h0, tv}, 32'h1);
    chk("f1_datos", {16'h0, d3, d2, d1, d0}, 32'h4321);
    chk("f1_cambio", {31'h0, ca}, 32'h1);
    dwell(4'hE, 7'h79, P); dwell(4'hD, 7'h24, P); dwell(4'hB, 7'h30, P); dwell(4'h7, 7'h19, P);
    chk("f2_tv", {31'h0, tv}, 32'h1);
    chk("f2_cambio", {31'h0, ca}, 32'h0);

    // Dwell one short of the stability threshold, then extend it
    dwell(4'hD, 7'h24, P); dwell(4'hB, 7'h30, P); dwell(4'h7, 7'h19, P);
    dwell(4'hE, 7'h40, P - 1);
    chk("short_no_frame", {31'h0, tv}, 32'h0);
    dwell(4'hE, 7'h40, 1);
    chk("ext_tv", {31'h0, tv}, 32'h1);
    chk("ext_datos", {16'h0, d3, d2, d1, d0}, 32'h4320);

    // Unknown pattern
    dwell(4'hE, 7'h7F, P);
    chk("err_patron", {31'h0, ep}, 32'h1);
    dwell(4'hD, 7'h24, P); dwell(4'hB, 7'h30, P); dwell(4'h7, 7'h19, P);
    chk("digit0_missing", {31'h0, tv}, 32'h0);
    dwell(4'hE, 7'h0E, P);
    chk("f_tv", {31'h0, tv}, 32'h1);
    chk("f_datos", {16'h0, d3, d2, d1, d0}, 32'h432F);
    chk("err_patron_sticky", {31'h0, ep}, 32'h1);

    // Multiple anodes and blank
    dwell(4'hC, 7'h00, P);
    chk("err_anodo", {31'h0, ea}, 32'h1);
    dwell(4'hF, 7'h7F, P);
    chk("blank_no_frame", {31'h0, tv}, 32'h0);
    chk("blank_datos", {16'h0, d3, d2, d1, d0}, 32'h432F);

    // Reset mid-frame discards partial capture
    dwell(4'hE, tbl[5], P); dwell(4'hD, tbl[6], P);
    do_reset();
    chk("rst_errs", {30'h0, ep, ea}, 32'h0);
    dwell(4'hB, tbl[7], P); dwell(4'h7, tbl[8], P);
    chk("rst_no_frame", {31'h0, tv}, 32'h0);
    dwell(4'hE, tbl[5], P); dwell(4'hD, tbl[6], P);
    chk("rst_frame_tv", {31'h0, tv}, 32'h1);
    chk("rst_frame_datos", {16'h0, d3, d2, d1, d0}, 32'h8765);

    // Scanning driver loopback
    scan_frame(16'h4321, 8, s_d, s_tv, s_ca);
    chk("loop1_tv", {31'h0, s_tv}, 32'h1);
    chk("loop1_datos", {16'h0, s_d}, 32'h4321);
    chk("loop1_cambio", {31'h0, s_ca}, 32'h1);
    scan_frame(16'h4321, 8, s_d, s_tv, s_ca);
    chk("loop2_tv", {31'h0, s_tv}, 32'h1);
    chk("loop2_cambio", {31'h0, s_ca}, 32'h0);

    // Randomized dwells; anode never all-low so post-reset sampling stays unambiguous
    for (int i = 0; i < 500; i++) begin
      case ($urandom % 6)
        0: r_an = 4'hE;
        1: r_an = 4'hD;
        2: r_an = 4'hB;
        3: r_an = 4'h7;
        4: r_an = 4'hF;
        default: r_an = 4'($urandom_range(1, 14));
      endcase
      if ($urandom % 150 == 0) do_reset();
      dwell(r_an, ($urandom % 4 != 0) ? tbl[$urandom % 16] : 7'($urandom), $urandom_range(1, 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/monitor_display_7segmentos.md
Name: monitor_display_7segmentos

Overview:
- Receiving end of the multiplexed 7-segment display interface: watches the active-low segment and anode lines driven by Controlador_display_7segmentos.
- Recovers the four displayed hex nibbles from those lines.
- Publishes the four nibbles atomically once a full scan frame has been captured.
- Used as an on-chip self-check and loopback monitor on Basys 3, and as a scoreboard front-end in benches.

Parameters:
P_ESTABLE, 4, consecutive identical samples of {anode, segments} required before a digit is captured (legal range 1..255).

Ports:
i_Reloj  input  1  system clock; all logic on rising edge
i_Reset  input  1  asynchronous, active-low reset
i_Segmentos  input  7  segment lines, active-low; bit6=g … bit0=a; same clock domain, no synchroniser
i_Anodo_4_Bits  input  4  anode lines, active-low; bit n low selects digit n
o_Datos_0  output  4  recovered digit 0 (anode bit 0)
o_Datos_1  output  4  recovered digit 1
o_Datos_2  output  4  recovered digit 2
o_Datos_3  output  4  recovered digit 3
o_Trama_Valida  output  1  one-cycle pulse when o_Datos_x are updated
o_Cambio  output  1  qualifies o_Trama_Valida: published frame differs from previous one
o_Error_Patron  output  1  sticky: an unknown segment pattern was captured
o_Error_Anodo  output  1  sticky: more than one anode low at capture time

Behaviour:
- Reset (i_Reset=0, asynchronous):
  - All outputs 0; stability counter 0.
  - Capture mask 4'b0000; shadow and previous-published registers 0.
  - The capture-done flag for the current dwell is cleared.
- Input registering and stability:
  - {i_Anodo_4_Bits, i_Segmentos} is registered every cycle into r_Previo.
  - Counter resets to 0 when the current inputs differ from r_Previo.
  - Otherwise the counter increments, saturating at P_ESTABLE.
- Capture strobe:
  - Fires once per dwell, on the edge where the inputs have been sampled identical on P_ESTABLE consecutive edges.
  - Counts the first edge of the dwell as 1.
  - With P_ESTABLE=1, fires on the first edge of each new input value.
- On capture:
  - Anodes 4'b1111 (blank): no action.
  - Exactly one anode low and the pattern is known: write the nibble to shadow[n] and set mask[n]. If mask[n] is already set, the latest value wins.
  - Exactly one anode low and the pattern is unknown: set o_Error_Patron; shadow and mask unchanged.
  - More than one anode low: set o_Error_Anodo; no shadow write.
- Decode table (active-low, gfedcba):
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
  - 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E
  - Any other value is unknown.
- Frame completion:
  - Occurs at the capture edge where mask (including the bit being set) becomes 4'b1111.
  - On that same edge: o_Datos_x <= shadow (with the new nibble merged) and the mask clears to 0.
  - On that same edge, o_Trama_Valida <= 1 for exactly one cycle.
  - On that same edge, o_Cambio <= (new frame != previous published frame); the previous-published register is updated.
  - o_Cambio is 0 whenever o_Trama_Valida is 0.
- Latency: o_Trama_Valida is high in the cycle after the P_ESTABLE-th stable sample of the last missing digit.
- Digit order does not matter; only completeness of the mask.
- Error flags: stay set until reset; they do not block frame tracking.
- Reset mid-frame: partial mask and shadow are discarded; four fresh captures are needed.

Decomposition:
- Shared package:
  - Sixteen segment-pattern constants and the blank pattern.
  - Anode blank constant 4'b1111.
  - Default P_ESTABLE.
- One combinational sub-module, decodificador_7seg_a_hex:
  - Input: 7-bit pattern. Outputs: 4-bit nibble and 1-bit valid.
  - Reused by benches as the reference decoder.

Test Plan:
1. Hold i_Reset=0 for 3 cycles with random inputs -> all outputs 0; no o_Trama_Valida pulse.
2. P_ESTABLE=4; dwell 4 cycles each on (1110,79), (1101,24), (1011,30), (0111,19) -> one o_Trama_Valida pulse; Datos_0..3 = 1,2,3,4; o_Cambio=1. Repeat the identical frame -> pulse with o_Cambio=0.
3. Dwell 3 cycles on (1110,40), with digits 1..3 already captured -> no capture and no frame. Extend to 4 cycles -> frame published with Datos_0=0.
4. Capture (1110,7F) -> o_Error_Patron=1 and stays 1; digit 0 remains uncaptured. Then send (1110,0E) -> frame completes with Datos_0=F.
5. Capture (1100,00) -> o_Error_Anodo=1 and no shadow write. Capture blank 1111 -> no effect.
6. Capture digits 0 and 1, pulse i_Reset low mid-frame, then capture digits 2 and 3 only -> no frame. After digits 0 and 1 are captured again -> frame pulses.
7. Loopback with Controlador_display_7segmentos, i_Datos = 1,2,3,4 -> recovered 1,2,3,4 with o_Cambio=1 on the first frame, then 0.
